// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end.
// Holds the instruction-fetch FSM encoding, the default reset PC, the
// instruction field bit positions and a word-alignment helper.
package mips_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2
  } fetch_state_e;

  localparam logic [DATA_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Instruction field positions
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int JIDX_MSB   = 25;
  localparam int JIDX_LSB   = 0;
  localparam int JIDX_W     = JIDX_MSB - JIDX_LSB + 1;

  // Every PC value is a word address; low two bits are forced to zero.
  function automatic logic [DATA_W-1:0] word_align(input logic [DATA_W-1:0] addr);
    return {addr[DATA_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_next_pc_sel.sv
// next_pc_sel: combinational next-PC selection for the fetch stage.
// Ports:
//   pc_plus4  - address following the issued instruction
//   instr_idx - jump index field of the issued instruction
//   imm_ext   - sign-extended branch immediate (word offset)
//   jmp       - jump decode
//   branch    - branch decode
//   zero      - ALU zero flag
//   next_pc   - selected next PC (jump > taken branch > sequential)
module next_pc_sel
  import mips_pkg::*;
(
  input  logic [DATA_W-1:0]        pc_plus4,
  input  logic [JIDX_W-1:0]        instr_idx,
  input  logic signed [DATA_W-1:0] imm_ext,
  input  logic                     jmp,
  input  logic                     branch,
  input  logic                     zero,
  output logic [DATA_W-1:0]        next_pc
);

  // Jump keeps the region bits of the sequential address.
  function automatic logic [DATA_W-1:0] jump_target(input logic [DATA_W-1:0] seq,
                                                    input logic [JIDX_W-1:0] idx);
    return {seq[DATA_W-1:DATA_W-4], idx, 2'b00};
  endfunction

  // Word offset scaled to bytes; the carry out of bit 31 is dropped so
  // targets wrap modulo 2^32.
  function automatic logic [DATA_W-1:0] branch_target(input logic [DATA_W-1:0] seq,
                                                      input logic signed [DATA_W-1:0] imm);
    logic signed [DATA_W-1:0] byte_off;
    byte_off = imm <<< 2;
    return word_align(seq + DATA_W'(unsigned'(byte_off)));
  endfunction

  always_comb begin
    next_pc = word_align(pc_plus4);
    if (jmp) begin
      next_pc = jump_target(pc_plus4, instr_idx);
    end else if (branch && zero) begin
      next_pc = branch_target(pc_plus4, imm_ext);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: instruction-fetch stage of the MIPS core.
// Owns the PC, fetches from instruction memory over req/ack and presents
// the fetched word downstream over valid/ready. The next PC is resolved
// from jmp/branch/zero/imm_ext on the edge that retires the instruction.
// Ports:
//   clk, rst_n               - clock, asynchronous active-low reset
//   imem_req/addr/ack/rdata  - instruction memory handshake
//   instr, opcode, funct     - issued instruction and its decode fields
//   pc, pc_plus4             - address of current instruction and successor
//   instr_valid/instr_ready  - downstream handshake
//   jmp, branch, zero, imm_ext - resolved control for the issued instruction
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        jmp,
  input  logic        branch,
  input  logic        zero,
  input  logic [31:0] imm_ext
);

  fetch_state_e      state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] next_pc;
  logic              fetch_done;
  logic              issue_done;

  assign fetch_done = (state_q == ST_FETCH) && imem_ack;
  assign issue_done = (state_q == ST_ISSUE) && instr_ready;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= word_align(RESET_PC);
      instr_q <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: if (imem_ack) state_d = ST_ISSUE;
      ST_ISSUE: if (instr_ready) state_d = ST_FETCH;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath updates: instr only on capture, pc only on retire
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    if (fetch_done) begin
      instr_d = imem_rdata;
    end
    if (issue_done) begin
      pc_d = next_pc;
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    imem_req    = (state_q == ST_FETCH);
    instr_valid = (state_q == ST_ISSUE);
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign pc_plus4  = pc_q + 32'd4;
  assign instr     = instr_q;
  assign opcode    = instr_q[OPCODE_MSB:OPCODE_LSB];
  assign funct     = instr_q[FUNCT_MSB:FUNCT_LSB];

  next_pc_sel u_next_pc_sel (
    .pc_plus4  (pc_plus4),
    .instr_idx (instr_q[JIDX_MSB:JIDX_LSB]),
    .imm_ext   (imm_ext),
    .jmp       (jmp),
    .branch    (branch),
    .zero      (zero),
    .next_pc   (next_pc)
  );

endmodule
